// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI serial-SRAM responder.
package spi_sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WRITE,
        READ,
        IGNORE
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 24;

endpackage

// File: rtl/sram_byte_mem.sv
// Byte-wide single-port memory: synchronous write, registered read (1-clk latency).
module sram_byte_mem #(
    parameter int ADDR_W    = 17,
    parameter int MEM_BYTES = 131072
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a serial SRAM (READ 0x03 / WRITE 0x02, 24-bit address,
// auto-incrementing byte stream), oversampled in the clk domain.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int MEM_BYTES   = 131072,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic sck,
    input  logic css,
    input  logic sdi,
    output logic sdo,
    output logic sdo_oe,
    output logic frame_done,
    output logic cmd_err
);

    logic sck_s, css_s, sdi_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sck_s = sck;
            assign css_s = css;
            assign sdi_s = sdi;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sck_q, css_q, sdi_q;
            // css resets low so a select held low across reset never looks like a fresh deselect
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    sck_q <= '0;
                    css_q <= '0;
                    sdi_q <= '0;
                end else begin
                    sck_q[0] <= sck;
                    css_q[0] <= css;
                    sdi_q[0] <= sdi;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sck_q[i] <= sck_q[i-1];
                        css_q[i] <= css_q[i-1];
                        sdi_q[i] <= sdi_q[i-1];
                    end
                end
            end
            assign sck_s = sck_q[SYNC_STAGES-1];
            assign css_s = css_q[SYNC_STAGES-1];
            assign sdi_s = sdi_q[SYNC_STAGES-1];
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(MEM_BYTES - 1)) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    state_e            state_q;
    logic              sck_prev_q;
    logic              armed_q;
    logic [4:0]        bit_cnt_q;
    logic [ADDR_W-2:0] shift_q;
    logic              rd_mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_q;
    logic [2:0]        tx_cnt_q;
    logic              mem_we_q;
    logic [7:0]        wdata_q;
    logic [7:0]        mem_rdata;
    logic              sdo_q, sdo_oe_q, frame_done_q, cmd_err_q;

    logic              rise_d, fall_d;
    logic [ADDR_W-1:0] shift_d;

    assign rise_d  = sck_s & ~sck_prev_q;
    assign fall_d  = ~sck_s & sck_prev_q;
    // Only the low ADDR_W address bits are ever needed, so older bits fall off the end
    assign shift_d = {shift_q, sdi_s};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            sck_prev_q   <= 1'b0;
            armed_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rd_mode_q    <= 1'b0;
            addr_q       <= '0;
            tx_q         <= '0;
            tx_cnt_q     <= '0;
            mem_we_q     <= 1'b0;
            wdata_q      <= '0;
            sdo_q        <= 1'b0;
            sdo_oe_q     <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            sck_prev_q   <= sck_s;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            if (css_s) begin
                armed_q   <= 1'b1;
                if (state_q != IDLE) begin
                    frame_done_q <= 1'b1;
                end
                state_q   <= IDLE;
                sdo_q     <= 1'b0;
                sdo_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                // The clk carrying the write pulse also advances to the next byte address
                if (mem_we_q) begin
                    addr_q <= addr_inc(addr_q);
                end
                case (state_q)
                    IDLE: begin
                        if (armed_q) begin
                            state_q   <= CMD;
                            bit_cnt_q <= '0;
                        end
                    end
                    CMD: begin
                        if (rise_d) begin
                            shift_q <= shift_d[ADDR_W-2:0];
                            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                                bit_cnt_q <= '0;
                                if (shift_d[7:0] == CMD_WRITE) begin
                                    state_q   <= ADDR;
                                    rd_mode_q <= 1'b0;
                                end else if (shift_d[7:0] == CMD_READ) begin
                                    state_q   <= ADDR;
                                    rd_mode_q <= 1'b1;
                                end else begin
                                    state_q   <= IGNORE;
                                    cmd_err_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise_d) begin
                            shift_q <= shift_d[ADDR_W-2:0];
                            if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                                bit_cnt_q <= '0;
                                addr_q    <= shift_d;
                                tx_cnt_q  <= '0;
                                state_q   <= rd_mode_q ? READ : WRITE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    WRITE: begin
                        if (rise_d) begin
                            shift_q <= shift_d[ADDR_W-2:0];
                            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                                bit_cnt_q <= '0;
                                mem_we_q  <= 1'b1;
                                wdata_q   <= shift_d[7:0];
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    READ: begin
                        // The registered memory output acts as the prefetch register
                        if (fall_d) begin
                            sdo_oe_q <= 1'b1;
                            if (tx_cnt_q == 3'd0) begin
                                sdo_q <= mem_rdata[7];
                                tx_q  <= {mem_rdata[6:0], 1'b0};
                            end else begin
                                sdo_q <= tx_q[7];
                                tx_q  <= {tx_q[6:0], 1'b0};
                            end
                            tx_cnt_q <= tx_cnt_q + 3'd1;
                            if (tx_cnt_q == 3'd7) begin
                                addr_q <= addr_inc(addr_q);
                            end
                        end
                    end
                    IGNORE: begin
                        sdo_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    sram_byte_mem #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign sdo        = sdo_q;
    assign sdo_oe     = sdo_oe_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: bit-banged SPI controller with a read-data scoreboard.
module tb_spi_sram_responder;

    localparam int PH = 6;

    logic clk = 1'b0;
    logic nrst, sck, css, sdi;
    logic sdo, sdo_oe, frame_done, cmd_err;

    always #5 clk = ~clk;

    spi_sram_responder dut (
        .clk        (clk),
        .nrst       (nrst),
        .sck        (sck),
        .css        (css),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0, fd_cnt = 0, ce_cnt = 0, oe_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (dut.mem_we_q) we_cnt++;
        if (frame_done)   fd_cnt++;
        if (cmd_err)      ce_cnt++;
        if (sdo_oe)       oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sdi = tx[7-i];
            wait_clk(PH);
            rx  = {rx[6:0], sdo};
            sck = 1'b1;
            wait_clk(PH);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] d;
        spi_bits(tx, 8, d);
    endtask

    task automatic frame_start();
        css = 1'b0;
        wait_clk(PH);
    endtask

    task automatic frame_end();
        wait_clk(PH);
        css = 1'b1;
        wait_clk(4*PH);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        spi_byte(cmd);
        spi_byte(addr[23:16]);
        spi_byte(addr[15:8]);
        spi_byte(addr[7:0]);
    endtask

    task automatic read_frame(input logic [23:0] addr, input int nbytes);
        logic [7:0] rx;
        frame_start();
        spi_byte(8'h03);
        spi_byte(addr[23:16]);
        spi_byte(addr[15:8]);
        check("rd_oe_hdr", sdo_oe, 1'b0);
        spi_byte(addr[7:0]);
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(8'h00, 8, rx);
            if (exp_q.size() == 0) begin
                check("rd_sb_empty", 1, 0);
            end else begin
                check("rd_byte", rx, exp_q.pop_front());
            end
            check("rd_oe_data", sdo_oe, 1'b1);
        end
        frame_end();
        check("rd_oe_after", sdo_oe, 1'b0);
        check("rd_sdo_after", sdo, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int we0, fd0, ce0, oe0;
        logic [7:0] snap_a, snap_b;
        logic [7:0] rx;

        nrst = 1'b0; css = 1'b1; sck = 1'b0; sdi = 1'b0;
        wait_clk(3);
        check("rst_sdo", sdo, 1'b0);
        check("rst_sdo_oe", sdo_oe, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        nrst = 1'b1;
        wait_clk(4*PH);

        // Write then read back
        we0 = we_cnt; fd0 = fd_cnt;
        frame_start();
        send_hdr(8'h02, 24'h000010);
        spi_byte(8'hAB);
        spi_byte(8'hCD);
        frame_end();
        check("wr_mem10", dut.u_mem.mem[17'h00010], 8'hAB);
        check("wr_mem11", dut.u_mem.mem[17'h00011], 8'hCD);
        check("wr_we_cnt", we_cnt - we0, 2);
        check("wr_fd_cnt", fd_cnt - fd0, 1);

        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        fd0 = fd_cnt;
        read_frame(24'h000010, 2);
        check("rd_fd_cnt", fd_cnt - fd0, 1);

        // Address wrap at the top of memory
        we0 = we_cnt;
        frame_start();
        send_hdr(8'h02, 24'h01FFFF);
        spi_byte(8'h12);
        spi_byte(8'h34);
        frame_end();
        check("wrap_mem_top", dut.u_mem.mem[17'h1FFFF], 8'h12);
        check("wrap_mem_0", dut.u_mem.mem[17'h00000], 8'h34);
        check("wrap_we_cnt", we_cnt - we0, 2);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        read_frame(24'h01FFFF, 2);

        // Upper address bits are masked off
        snap_a = dut.u_mem.mem[17'h00021];
        snap_b = dut.u_mem.mem[17'h0001F];
        we0 = we_cnt;
        frame_start();
        send_hdr(8'h02, 24'hFE0020);
        spi_byte(8'h5A);
        frame_end();
        check("mask_mem20", dut.u_mem.mem[17'h00020], 8'h5A);
        check("mask_mem21", dut.u_mem.mem[17'h00021], snap_a);
        check("mask_mem1f", dut.u_mem.mem[17'h0001F], snap_b);
        check("mask_we_cnt", we_cnt - we0, 1);

        // Unsupported command
        we0 = we_cnt; fd0 = fd_cnt; ce0 = ce_cnt; oe0 = oe_cnt;
        frame_start();
        spi_byte(8'h05);
        check("bad_cmd_err", ce_cnt - ce0, 1);
        spi_byte(8'h00);
        spi_byte(8'h00);
        spi_byte(8'h00);
        spi_byte(8'hFF);
        frame_end();
        check("bad_cmd_err_once", ce_cnt - ce0, 1);
        check("bad_we_cnt", we_cnt - we0, 0);
        check("bad_oe_cnt", oe_cnt - oe0, 0);
        check("bad_fd_cnt", fd_cnt - fd0, 1);

        // Abort with a partial byte in flight
        snap_a = dut.u_mem.mem[17'h00041];
        we0 = we_cnt; fd0 = fd_cnt;
        frame_start();
        send_hdr(8'h02, 24'h000040);
        spi_byte(8'h9C);
        spi_bits(8'hF0, 4, rx);
        frame_end();
        check("abort_mem40", dut.u_mem.mem[17'h00040], 8'h9C);
        check("abort_mem41", dut.u_mem.mem[17'h00041], snap_a);
        check("abort_we_cnt", we_cnt - we0, 1);
        check("abort_fd_cnt", fd_cnt - fd0, 1);
        exp_q.push_back(8'h9C);
        read_frame(24'h000040, 1);

        // Reset in the middle of a read, css held low through release
        frame_start();
        send_hdr(8'h03, 24'h000010);
        spi_bits(8'h00, 4, rx);
        check("rstrd_bits", rx[3:0], 4'hA);
        wait_clk(4);
        check("rstrd_oe_pre", sdo_oe, 1'b1);
        check("rstrd_sdo_pre", sdo, 1'b1);
        nrst = 1'b0;
        #1;
        check("rstrd_sdo", sdo, 1'b0);
        check("rstrd_oe", sdo_oe, 1'b0);
        wait_clk(2);
        nrst = 1'b1;
        snap_a = dut.u_mem.mem[17'h00050];
        we0 = we_cnt; fd0 = fd_cnt; oe0 = oe_cnt; ce0 = ce_cnt;
        send_hdr(8'h02, 24'h000050);
        spi_byte(8'h77);
        check("rstrd_idle_we", we_cnt - we0, 0);
        check("rstrd_idle_oe", oe_cnt - oe0, 0);
        frame_end();
        check("rstrd_idle_fd", fd_cnt - fd0, 0);
        check("rstrd_idle_ce", ce_cnt - ce0, 0);
        check("rstrd_mem50", dut.u_mem.mem[17'h00050], snap_a);
        exp_q.push_back(8'hAB);
        read_frame(24'h000010, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
